// File: rtl/image_roi_crop_pkg.sv
// Shared types for image_roi_crop: the FSM state encoding and the pixel type.
package image_roi_crop_pkg;

  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_FRAME = 2'd2
  } state_e;

endpackage

// File: rtl/image_roi_crop.sv
// Crops a fixed region of interest out of a vsync/href pixel stream with a 1-cycle latency.
// Define IMAGE_ROI_CROP_FRAME_CHECK_EN to build the frame_err geometry checker.
//
// state   | meaning
// S_WAIT  | out of reset, a frame may be in progress; wait for vsync low
// S_IDLE  | between frames; wait for a vsync rising edge
// S_FRAME | frame active; columns and rows are counted
module image_roi_crop
  import image_roi_crop_pkg::*;
#(
  parameter int C_IMG_WIDTH  = 1024,
  parameter int C_IMG_HEIGHT = 768,
  parameter int C_ROI_X      = 0,
  parameter int C_ROI_Y      = 0,
  parameter int C_ROI_WIDTH  = 640,
  parameter int C_ROI_HEIGHT = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               per_img_vsync,
  input  logic               per_img_href,
  input  logic [PIXEL_W-1:0] per_img_gray,
  output logic               post_img_vsync,
  output logic               post_img_href,
  output logic [PIXEL_W-1:0] post_img_gray,
  output logic               frame_err
);

  if (C_ROI_X < 0 || C_ROI_Y < 0 || C_ROI_WIDTH < 1 || C_ROI_HEIGHT < 1 ||
      C_ROI_X + C_ROI_WIDTH > C_IMG_WIDTH ||
      C_ROI_Y + C_ROI_HEIGHT > C_IMG_HEIGHT) begin : g_roi_check
    $error("image_roi_crop: ROI does not lie inside the input frame");
  end

  localparam int CW = $clog2(C_IMG_WIDTH + 1);
  localparam int RW = $clog2(C_IMG_HEIGHT + 1);

  localparam logic [CW-1:0] L_COL_MAX = CW'(C_IMG_WIDTH);
  localparam logic [RW-1:0] L_ROW_MAX = RW'(C_IMG_HEIGHT);
  localparam logic [CW-1:0] L_X_LO    = CW'(C_ROI_X);
  localparam logic [CW-1:0] L_X_LEN   = CW'(C_ROI_WIDTH);
  localparam logic [RW-1:0] L_Y_LO    = RW'(C_ROI_Y);
  localparam logic [RW-1:0] L_Y_LEN   = RW'(C_ROI_HEIGHT);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_vsync_d;
  logic          r_href_d;
  logic [CW-1:0] r_col_cnt;
  logic [RW-1:0] r_row_cnt;
  logic          r_post_vsync;
  logic          r_post_href;
  pixel_t        r_post_gray;

  logic          w_enter;
  logic          w_active;
  logic          w_href_fall;
  logic [CW-1:0] w_col_cur;
  logic [RW-1:0] w_row_cur;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;
  logic [CW-1:0] w_col_off;
  logic [RW-1:0] w_row_off;
  logic          w_in_roi;
  logic          w_pix_vld;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_WAIT:  if (!per_img_vsync) w_state_nxt = S_IDLE;
      S_IDLE:  if (per_img_vsync && !r_vsync_d) w_state_nxt = S_FRAME;
      S_FRAME: if (!per_img_vsync) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // The vsync-rise cycle already belongs to the frame, so a pixel there is column 0, row 0.
  assign w_enter     = (r_state != S_FRAME) && (w_state_nxt == S_FRAME);
  assign w_active    = (w_state_nxt == S_FRAME);
  assign w_href_fall = r_href_d && !per_img_href && !w_enter;
  assign w_col_cur   = w_enter ? '0 : r_col_cnt;
  assign w_row_cur   = w_enter ? '0 : r_row_cnt;

  always_comb begin
    w_col_nxt = w_col_cur;
    w_row_nxt = w_row_cur;
    if (per_img_href) begin
      if (w_col_cur != L_COL_MAX) w_col_nxt = w_col_cur + 1'b1;
    end else if (w_href_fall) begin
      w_col_nxt = '0;
      if (w_row_cur != L_ROW_MAX) w_row_nxt = w_row_cur + 1'b1;
    end
  end

  // Offset compare: counts below the origin wrap to values larger than the ROI size.
  assign w_col_off = w_col_cur - L_X_LO;
  assign w_row_off = w_row_cur - L_Y_LO;
  assign w_in_roi  = (w_col_off < L_X_LEN) && (w_row_off < L_Y_LEN);
  assign w_pix_vld = per_img_href && w_in_roi && w_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_WAIT;
      r_vsync_d    <= 1'b0;
      r_href_d     <= 1'b0;
      r_col_cnt    <= '0;
      r_row_cnt    <= '0;
      r_post_vsync <= 1'b0;
      r_post_href  <= 1'b0;
      r_post_gray  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_vsync_d    <= per_img_vsync;
      r_href_d     <= per_img_href;
      r_col_cnt    <= w_active ? w_col_nxt : '0;
      r_row_cnt    <= w_active ? w_row_nxt : '0;
      r_post_vsync <= per_img_vsync && (r_state != S_WAIT);
      r_post_href  <= w_pix_vld;
      r_post_gray  <= w_pix_vld ? per_img_gray : '0;
    end
  end

  assign post_img_vsync = r_post_vsync;
  assign post_img_href  = r_post_href;
  assign post_img_gray  = r_post_gray;

`ifdef IMAGE_ROI_CROP_FRAME_CHECK_EN
  logic r_line_err;
  logic r_frame_err;
  logic w_in_frame;
  logic w_line_bad;
  logic w_frame_end;

  // Over-long lines and extra lines saturate the counters, so activity at saturation is an error too.
  assign w_in_frame  = (r_state == S_FRAME) || w_enter;
  assign w_line_bad  = w_in_frame &&
                       ((w_href_fall && (w_col_cur != L_COL_MAX)) ||
                        (per_img_href && (w_col_cur == L_COL_MAX)) ||
                        (w_href_fall && (w_row_cur == L_ROW_MAX)));
  assign w_frame_end = (r_state == S_FRAME) && (w_state_nxt == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_line_err  <= w_active ? ((w_enter ? 1'b0 : r_line_err) || w_line_bad) : 1'b0;
      r_frame_err <= w_frame_end &&
                     (r_line_err || w_line_bad || (w_row_nxt != L_ROW_MAX));
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_image_roi_crop.sv
// Directed self-checking bench for image_roi_crop on a reduced 116x54 frame, ROI (100,50,16,4).
`timescale 1ns/1ps
module tb_image_roi_crop;

  localparam int W    = 116;
  localparam int H    = 54;
  localparam int RX   = 100;
  localparam int RY   = 50;
  localparam int RWD  = 16;
  localparam int RHT  = 4;
  localparam int NPIX = RWD * RHT;
`ifdef IMAGE_ROI_CROP_FRAME_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       vs_in;
  logic       hs_in;
  logic [7:0] px_in;
  logic       post_img_vsync;
  logic       post_img_href;
  logic [7:0] post_img_gray;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  int         cyc = 0;
  logic [7:0] outq[$];
  int         out_lines;
  int         err_pulses;
  int         first_out_cyc;
  int         roi_in_cyc;
  logic       prev_out_href;

  image_roi_crop #(
    .C_IMG_WIDTH (W),
    .C_IMG_HEIGHT(H),
    .C_ROI_X     (RX),
    .C_ROI_Y     (RY),
    .C_ROI_WIDTH (RWD),
    .C_ROI_HEIGHT(RHT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .per_img_vsync (vs_in),
    .per_img_href  (hs_in),
    .per_img_gray  (px_in),
    .post_img_vsync(post_img_vsync),
    .post_img_href (post_img_href),
    .post_img_gray (post_img_gray),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r * 3 + c) & 255);
  endfunction

  function automatic int roi_mismatches();
    int n = 0;
    for (int k = 0; k < outq.size(); k++) begin
      int kk = k % NPIX;
      if (outq[k] !== pix(RY + kk / RWD, RX + kk % RWD)) n++;
    end
    return n;
  endfunction

  task automatic reset_stats();
    outq.delete();
    out_lines     = 0;
    err_pulses    = 0;
    first_out_cyc = -1;
    roi_in_cyc    = -1;
    prev_out_href = 1'b0;
  endtask

  task automatic step(input logic vs, input logic hs, input logic [7:0] px);
    vs_in = vs;
    hs_in = hs;
    px_in = px;
    @(posedge clk);
    #1;
    cyc++;
    if (post_img_href === 1'b1) begin
      outq.push_back(post_img_gray);
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (!prev_out_href) out_lines++;
    end
    prev_out_href = (post_img_href === 1'b1);
    if (frame_err !== 1'b0) err_pulses++;
  endtask

  task automatic send_line(input int r, input int len);
    for (int c = 0; c < len; c++) begin
      if (r == RY && c == RX && roi_in_cyc < 0) roi_in_cyc = cyc;
      step(1'b1, 1'b1, pix(r, c));
    end
    repeat (3) step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int lead, input int long_row, input int stop_row, input int gap_after);
    for (int i = 0; i < lead; i++) step(1'b1, 1'b0, 8'h00);
    for (int r = 0; r < H; r++) begin
      if (r == stop_row) begin
        for (int c = 0; c < 20; c++) step(1'b1, 1'b1, pix(r, c));
        step(1'b0, 1'b1, pix(r, 20));
        for (int i = 1; i < gap_after; i++) step(1'b0, 1'b0, 8'h00);
        return;
      end
      send_line(r, (r == long_row) ? W + 6 : W);
    end
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < gap_after; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 8'h55);
    step(1'b1, 1'b1, 8'h66);
    total++; if (post_img_vsync !== 1'b0) begin bad++; $display("FAIL rst_vsync got=%b want=0", post_img_vsync); end
    total++; if (post_img_href !== 1'b0) begin bad++; $display("FAIL rst_href got=%b want=0", post_img_href); end
    total++; if (post_img_gray !== 8'h00) begin bad++; $display("FAIL rst_gray got=%h want=00", post_img_gray); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err got=%b want=0", frame_err); end
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 8'h00);
    total++; if (post_img_vsync !== 1'b0) begin bad++; $display("FAIL idle_vsync got=%b want=0", post_img_vsync); end
  endtask

  task automatic test_crop();
    logic [7:0] first_px;
    reset_stats();
    step(1'b1, 1'b0, 8'h00);
    total++; if (post_img_vsync !== 1'b1) begin bad++; $display("FAIL crop_vsync_lat got=%b want=1", post_img_vsync); end
    send_frame(1, -1, -1, 4);
    first_px = (outq.size() > 0) ? outq[0] : 8'hxx;
    total++; if (outq.size() !== NPIX) begin bad++; $display("FAIL crop_count got=%0d want=%0d", outq.size(), NPIX); end
    total++; if (out_lines !== RHT) begin bad++; $display("FAIL crop_lines got=%0d want=%0d", out_lines, RHT); end
    total++; if (roi_mismatches() !== 0) begin bad++; $display("FAIL crop_pixels got=%0d want=0", roi_mismatches()); end
    total++; if (first_px !== 8'hFA) begin bad++; $display("FAIL crop_first got=%h want=fa", first_px); end
    total++; if (first_out_cyc - roi_in_cyc !== 1) begin bad++; $display("FAIL crop_latency got=%0d want=1", first_out_cyc - roi_in_cyc); end
    total++; if (err_pulses !== 0) begin bad++; $display("FAIL crop_err got=%0d want=0", err_pulses); end
    total++; if (post_img_vsync !== 1'b0) begin bad++; $display("FAIL crop_vsync_end got=%b want=0", post_img_vsync); end
  endtask

  task automatic test_long_line();
    reset_stats();
    send_frame(2, RY + 1, -1, 4);
    total++; if (outq.size() !== NPIX) begin bad++; $display("FAIL long_count got=%0d want=%0d", outq.size(), NPIX); end
    total++; if (roi_mismatches() !== 0) begin bad++; $display("FAIL long_pixels got=%0d want=0", roi_mismatches()); end
    total++; if (err_pulses !== EXP_ERR) begin bad++; $display("FAIL long_err got=%0d want=%0d", err_pulses, EXP_ERR); end
  endtask

  task automatic test_early_end();
    reset_stats();
    send_frame(2, -1, RY + 2, 4);
    total++; if (outq.size() !== 2 * RWD) begin bad++; $display("FAIL early_count got=%0d want=%0d", outq.size(), 2 * RWD); end
    total++; if (roi_mismatches() !== 0) begin bad++; $display("FAIL early_pixels got=%0d want=0", roi_mismatches()); end
    total++; if (err_pulses !== EXP_ERR) begin bad++; $display("FAIL early_err got=%0d want=%0d", err_pulses, EXP_ERR); end
    reset_stats();
    send_frame(2, -1, -1, 4);
    total++; if (outq.size() !== NPIX) begin bad++; $display("FAIL after_early_count got=%0d want=%0d", outq.size(), NPIX); end
    total++; if (roi_mismatches() !== 0) begin bad++; $display("FAIL after_early_pixels got=%0d want=0", roi_mismatches()); end
    total++; if (err_pulses !== 0) begin bad++; $display("FAIL after_early_err got=%0d want=0", err_pulses); end
  endtask

  task automatic test_midframe_reset();
    reset_stats();
    step(1'b1, 1'b0, 8'h00);
    for (int r = 0; r < RY; r++) send_line(r, W);
    for (int c = 0; c <= RX + 5; c++) step(1'b1, 1'b1, pix(RY, c));
    total++; if (post_img_href !== 1'b1) begin bad++; $display("FAIL mid_href_before got=%b want=1", post_img_href); end
    rst = 1'b1;
    step(1'b1, 1'b1, pix(RY, RX + 6));
    total++; if (post_img_href !== 1'b0) begin bad++; $display("FAIL mid_rst_href got=%b want=0", post_img_href); end
    total++; if (post_img_vsync !== 1'b0) begin bad++; $display("FAIL mid_rst_vsync got=%b want=0", post_img_vsync); end
    total++; if (post_img_gray !== 8'h00) begin bad++; $display("FAIL mid_rst_gray got=%h want=00", post_img_gray); end
    for (int c = RX + 7; c < W; c++) step(1'b1, 1'b1, pix(RY, c));
    repeat (3) step(1'b1, 1'b0, 8'h00);
    send_line(RY + 1, W);
    rst = 1'b0;
    reset_stats();
    for (int r = RY + 2; r < H; r++) send_line(r, W);
    step(1'b1, 1'b0, 8'h00);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    total++; if (outq.size() !== 0) begin bad++; $display("FAIL mid_no_output got=%0d want=0", outq.size()); end
    total++; if (err_pulses !== 0) begin bad++; $display("FAIL mid_err got=%0d want=0", err_pulses); end
    reset_stats();
    send_frame(2, -1, -1, 4);
    total++; if (outq.size() !== NPIX) begin bad++; $display("FAIL mid_next_count got=%0d want=%0d", outq.size(), NPIX); end
    total++; if (roi_mismatches() !== 0) begin bad++; $display("FAIL mid_next_pixels got=%0d want=0", roi_mismatches()); end
  endtask

  task automatic test_back_to_back();
    reset_stats();
    send_frame(2, -1, -1, 1);
    send_frame(0, -1, -1, 4);
    total++; if (outq.size() !== 2 * NPIX) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", outq.size(), 2 * NPIX); end
    total++; if (out_lines !== 2 * RHT) begin bad++; $display("FAIL b2b_lines got=%0d want=%0d", out_lines, 2 * RHT); end
    total++; if (roi_mismatches() !== 0) begin bad++; $display("FAIL b2b_pixels got=%0d want=0", roi_mismatches()); end
    total++; if (err_pulses !== 0) begin bad++; $display("FAIL b2b_err got=%0d want=0", err_pulses); end
  endtask

  initial begin
    rst   = 1'b1;
    vs_in = 1'b0;
    hs_in = 1'b0;
    px_in = 8'h00;
    reset_stats();
    test_reset();
    test_crop();
    test_long_line();
    test_early_end();
    test_midframe_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
